// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Decides each cycle whether PC and the four pipeline registers load, hold
// or take a bubble. It also runs the RUN/HALT/RESUME machine for the halting
// syscall and keeps wrap-around performance counters.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   go                     resume pulse, honoured only in HALT
//   ID_*                   source registers read by the instruction in ID
//   EX_*                   valid/control/destination/redirect info of EX
//   WB_Syscall_halt        halting syscall present in WB
//   *_Enable               1 = hold the stage, 0 = load (combinational)
//   IF_ID_rst, ID_EX_rst   1 = load a bubble (combinational)
//   halted                 registered, high while in HALT
//   *_cnt                  registered performance counters, CNT_W bits
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [4:0]       ID_rs_no,
  input  logic [4:0]       ID_rt_no,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             EX_Effective,
  input  logic             EX_MemToReg,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_Rd_no,
  input  logic             EX_redirect,
  input  logic             EX_is_branch,
  input  logic             WB_Syscall_halt,
  output logic             PC_Enable,
  output logic             IF_ID_Enable,
  output logic             ID_EX_Enable,
  output logic             EX_MEM_Enable,
  output logic             MEM_WB_Enable,
  output logic             IF_ID_rst,
  output logic             ID_EX_rst,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_RESUME = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;

  logic lu, rd, hz;
  logic freeze_sel, flush_sel, stall_sel;

  // Hazard detection; the syscall is only seen in RUN (masked in RESUME).
  always_comb begin
    lu = EX_Effective & EX_MemToReg & EX_RegWrite & (EX_Rd_no != 5'd0) &
         ((ID_use_rs & (ID_rs_no == EX_Rd_no)) |
          (ID_use_rt & (ID_rt_no == EX_Rd_no)));
    rd = EX_Effective & EX_redirect;
    hz = WB_Syscall_halt & (state_q == ST_RUN);
  end

  // Priority selection: reset, freeze, redirect flush, load-use stall.
  always_comb begin
    freeze_sel = 1'b0;
    flush_sel  = 1'b0;
    stall_sel  = 1'b0;
    if (!rst) begin
      if ((state_q == ST_HALT) || hz) freeze_sel = 1'b1;
      else if (rd)                    flush_sel  = 1'b1;
      else if (lu)                    stall_sel  = 1'b1;
    end
  end

  // Stage controls, same-cycle.
  always_comb begin
    PC_Enable     = freeze_sel | stall_sel;
    IF_ID_Enable  = freeze_sel | stall_sel;
    ID_EX_Enable  = freeze_sel;
    EX_MEM_Enable = freeze_sel;
    MEM_WB_Enable = freeze_sel;
    IF_ID_rst     = flush_sel;
    ID_EX_rst     = flush_sel | stall_sel;
  end

  // Next state and counters.
  always_comb begin
    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (rst) begin
      state_d      = ST_RUN;
      cycle_cnt_d  = '0;
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
      branch_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_RUN:    if (hz) state_d = ST_HALT;
        ST_HALT:   if (go) state_d = ST_RESUME;
        ST_RESUME: state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
      if (!EX_MEM_Enable)                               cycle_cnt_d  = cycle_cnt_q + CNT_ONE;
      if (stall_sel)                                    stall_cnt_d  = stall_cnt_q + CNT_ONE;
      if (flush_sel)                                    flush_cnt_d  = flush_cnt_q + CNT_ONE;
      if (EX_Effective && EX_is_branch && !EX_MEM_Enable) branch_cnt_d = branch_cnt_q + CNT_ONE;
    end
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      halted_q     <= 1'b0;
      cycle_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      cycle_cnt_q  <= cycle_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign halted     = halted_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign branch_cnt = branch_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a rule-level model.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MOD = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst, go;
  logic [4:0] ID_rs_no, ID_rt_no, EX_Rd_no;
  logic ID_use_rs, ID_use_rt, EX_Effective, EX_MemToReg, EX_RegWrite;
  logic EX_redirect, EX_is_branch, WB_Syscall_halt;
  logic PC_Enable, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable, MEM_WB_Enable;
  logic IF_ID_rst, ID_EX_rst, halted;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, branch_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .go(go),
    .ID_rs_no(ID_rs_no), .ID_rt_no(ID_rt_no),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .EX_Effective(EX_Effective), .EX_MemToReg(EX_MemToReg),
    .EX_RegWrite(EX_RegWrite), .EX_Rd_no(EX_Rd_no),
    .EX_redirect(EX_redirect), .EX_is_branch(EX_is_branch),
    .WB_Syscall_halt(WB_Syscall_halt),
    .PC_Enable(PC_Enable), .IF_ID_Enable(IF_ID_Enable),
    .ID_EX_Enable(ID_EX_Enable), .EX_MEM_Enable(EX_MEM_Enable),
    .MEM_WB_Enable(MEM_WB_Enable), .IF_ID_rst(IF_ID_rst),
    .ID_EX_rst(ID_EX_rst), .halted(halted),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .branch_cnt(branch_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: machine mode and plain integer counters.
  bit m_halt = 1'b0;
  bit m_resume = 1'b0;
  int m_cyc = 0, m_stall = 0, m_flush = 0, m_br = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; go = 1'b0;
    ID_rs_no = 5'd0; ID_rt_no = 5'd0; ID_use_rs = 1'b0; ID_use_rt = 1'b0;
    EX_Effective = 1'b0; EX_MemToReg = 1'b0; EX_RegWrite = 1'b0;
    EX_Rd_no = 5'd0; EX_redirect = 1'b0; EX_is_branch = 1'b0;
    WB_Syscall_halt = 1'b0;
  endtask

  // One cycle: check combinational controls, clock, update model, check state.
  task automatic tick();
    bit lu, rdir, hz, freeze, flush, stall;
    logic [6:0] exp_ctl, got_ctl;
    @(negedge clk);
    lu = EX_Effective && EX_MemToReg && EX_RegWrite && (EX_Rd_no != 0) &&
         ((ID_use_rs && ID_rs_no == EX_Rd_no) || (ID_use_rt && ID_rt_no == EX_Rd_no));
    rdir = EX_Effective && EX_redirect;
    hz = WB_Syscall_halt && !m_halt && !m_resume;
    freeze = 0; flush = 0; stall = 0;
    if (rst)                 exp_ctl = 7'b00000_00;
    else if (m_halt || hz) begin exp_ctl = 7'b11111_00; freeze = 1; end
    else if (rdir)         begin exp_ctl = 7'b00000_11; flush = 1; end
    else if (lu)           begin exp_ctl = 7'b11000_01; stall = 1; end
    else                     exp_ctl = 7'b00000_00;
    got_ctl = {PC_Enable, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable, MEM_WB_Enable,
               IF_ID_rst, ID_EX_rst};
    check("ctl", 32'(got_ctl), 32'(exp_ctl));
    @(posedge clk);
    if (rst) begin
      m_halt = 0; m_resume = 0; m_cyc = 0; m_stall = 0; m_flush = 0; m_br = 0;
    end else begin
      if (!freeze) m_cyc = (m_cyc + 1) % CNT_MOD;
      if (stall)   m_stall = (m_stall + 1) % CNT_MOD;
      if (flush)   m_flush = (m_flush + 1) % CNT_MOD;
      if (EX_Effective && EX_is_branch && !freeze) m_br = (m_br + 1) % CNT_MOD;
      if (m_resume)          m_resume = 0;
      else if (m_halt && go) begin m_halt = 0; m_resume = 1; end
      else if (hz)           m_halt = 1;
    end
    #1;
    check("halted", 32'(halted), 32'(m_halt));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    check("branch_cnt", 32'(branch_cnt), 32'(m_br));
  endtask

  task automatic set_lw8();
    EX_Effective = 1; EX_MemToReg = 1; EX_RegWrite = 1; EX_Rd_no = 5'd8;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    check("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);

    // Load-use on rs, then a bubble in EX.
    idle_inputs(); set_lw8(); ID_rs_no = 5'd8; ID_use_rs = 1; tick();
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    idle_inputs(); ID_rs_no = 5'd8; ID_use_rs = 1; tick();

    // Taken branch together with load-use: redirect wins.
    idle_inputs(); set_lw8(); ID_rt_no = 5'd8; ID_use_rt = 1;
    EX_redirect = 1; EX_is_branch = 1; tick();
    check("rd_lu_flush_cnt", 32'(flush_cnt), 32'd1);
    check("rd_lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // No false hazards.
    idle_inputs(); set_lw8(); EX_Rd_no = 5'd0; ID_rs_no = 5'd0; ID_use_rs = 1; tick();
    idle_inputs(); set_lw8(); ID_rs_no = 5'd8; ID_use_rs = 0; tick();
    idle_inputs(); set_lw8(); EX_Effective = 0; ID_rs_no = 5'd8; ID_use_rs = 1; tick();

    // Syscall halt, 5 idle HALT cycles, go, masked RESUME, back to RUN.
    idle_inputs(); WB_Syscall_halt = 1; tick();
    for (int i = 0; i < 5; i++) tick();
    go = 1; tick();
    go = 0; tick();
    check("resume_freed", 32'(halted), 32'd0);
    idle_inputs(); tick(); tick();

    // Reset while halted.
    WB_Syscall_halt = 1; tick(); tick();
    rst = 1; go = 1; tick();
    check("rst_in_halt", 32'(halted), 32'd0);
    idle_inputs(); tick();

    // Counter wrap: 16 unfrozen cycles from reset.
    rst = 1; tick();
    idle_inputs();
    for (int i = 0; i < 16; i++) tick();
    check("cycle_wrap", 32'(cycle_cnt), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(59) == 0);
      go = ($urandom_range(3) == 0);
      ID_rs_no = 5'($urandom_range(3));
      ID_rt_no = 5'($urandom_range(3));
      ID_use_rs = 1'($urandom);
      ID_use_rt = 1'($urandom);
      EX_Effective = ($urandom_range(3) != 0);
      EX_MemToReg = 1'($urandom);
      EX_RegWrite = ($urandom_range(3) != 0);
      EX_Rd_no = 5'($urandom_range(3));
      EX_redirect = ($urandom_range(4) == 0);
      EX_is_branch = 1'($urandom);
      WB_Syscall_halt = ($urandom_range(11) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
